// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 keypad column scanner with whole-frame debounce and one-shot key reporting.
module keypad_scan #(
   parameter int SCAN_DIV     = 25000,
   parameter int DEBOUNCE_CNT = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_row,
   output logic [2:0] key_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_pressed
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [3:0] NONE = 4'hF;
   typedef enum logic {RELEASED, PRESSED} state_t;
   state_t      state;
   logic [3:0]  row_m, row_s, prev, cand, hits;
   logic [DW-1:0] div;
   logic [1:0]  col;
   logic [7:0]  snap, cnt, cnt_nxt;
   logic [11:0] bits;
   logic        tick, frame_end;
   function automatic logic [3:0] code_of(input int r, input int c);
      return r < 3 ? 4'(r * 3 + c + 1) : (c == 0 ? 4'd10 : c == 1 ? 4'd0 : 4'd11);
   endfunction
   assign tick = div == DW'(SCAN_DIV - 1);
   assign frame_end = tick && col == 2'd2;
   // column 2 is taken live from the synchroniser on the frame-end tick
   assign bits = {row_s, snap};
   always_comb begin
      cand = NONE;
      hits = '0;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 4; r++)
            if (bits[c * 4 + r]) begin
               hits = hits + 4'd1;
               cand = code_of(r, c);
            end
      cand = hits == 4'd1 ? cand : NONE;
      cnt_nxt = cand == prev ? (cnt == 8'(DEBOUNCE_CNT) ? cnt : cnt + 8'd1) : 8'd0;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         row_m       <= '0;
         row_s       <= '0;
         div         <= '0;
         col         <= '0;
         snap        <= '0;
         prev        <= NONE;
         cnt         <= '0;
         state       <= RELEASED;
         key_col     <= 3'b001;
         key_code    <= 4'hF;
         key_valid   <= 1'b0;
         key_pressed <= 1'b0;
      end else begin
         row_m     <= key_row;
         row_s     <= row_m;
         key_valid <= 1'b0;
         div       <= tick ? '0 : div + DW'(1);
         if (tick) begin
            col     <= col == 2'd2 ? 2'd0 : col + 2'd1;
            key_col <= {key_col[1:0], key_col[2]};
            if (col != 2'd2) snap[{col[0], 2'b00} +: 4] <= row_s;
         end
         if (frame_end) begin
            prev <= cand;
            cnt  <= cnt_nxt;
            if (cnt_nxt == 8'(DEBOUNCE_CNT)) begin
               if (state == RELEASED && cand != NONE) begin
                  state       <= PRESSED;
                  key_code    <= cand;
                  key_valid   <= 1'b1;
                  key_pressed <= 1'b1;
               end else if (state == PRESSED && cand == NONE) begin
                  state       <= RELEASED;
                  key_pressed <= 1'b0;
               end
            end
         end
      end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: frame-level keypad model driving key_row from key_col, checked against a run-length debounce model.
module tb_keypad_scan;
   localparam int SD = 4, DB = 2, NONE = 15;
   logic clk = 1'b0, reset = 1'b0;
   logic [3:0] key_row, key_code;
   logic [2:0] key_col;
   logic key_valid, key_pressed;
   logic [11:0] keys = '0;
   int passed = 0, total = 0;
   int m_prev, m_run, m_code;
   bit m_pressed, m_valid;
   int keymap[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
   typedef struct {logic [11:0] k; bit v; bit p; int code;} vec_t;
   vec_t tab[$];

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
      .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed));

   always #5 clk = ~clk;

   // physical keypad: a pressed key at (r,c) connects column c to row r
   always_comb begin
      key_row = '0;
      for (int r = 0; r < 4; r++) key_row[r] = |(keys[r * 3 +: 3] & key_col);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int cand_of(input logic [11:0] k);
      if ($countones(k) != 1) return NONE;
      for (int i = 0; i < 12; i++) if (k[i]) return keymap[i];
      return NONE;
   endfunction

   task automatic model_reset();
      m_prev = NONE; m_run = 1; m_pressed = 0; m_code = NONE; m_valid = 0;
   endtask

   task automatic model_frame(input logic [11:0] k);
      int c;
      c = cand_of(k);
      m_run = (c == m_prev) ? m_run + 1 : 1;
      m_prev = c;
      m_valid = 0;
      if (m_run >= DB + 1) begin
         if (!m_pressed && c != NONE) begin m_pressed = 1; m_code = c; m_valid = 1; end
         else if (m_pressed && c == NONE) m_pressed = 0;
      end
   endtask

   task automatic run_frame(input logic [11:0] k);
      keys = k;
      model_frame(k);
      for (int j = 1; j <= 12; j++) begin
         @(posedge clk); #1;
         check("key_col", key_col, 1 << ((j % 12) / 4));
         check("key_valid", key_valid, j == 12 ? m_valid : 0);
      end
      check("key_pressed", key_pressed, m_pressed);
      check("key_code", key_code, m_code);
   endtask

   initial begin
      tab.push_back('{12'h010, 0, 0, 15}); tab.push_back('{12'h010, 0, 0, 15});
      tab.push_back('{12'h010, 1, 1, 5});
      repeat (3) tab.push_back('{12'h010, 0, 1, 5});
      tab.push_back('{12'h000, 0, 1, 5}); tab.push_back('{12'h000, 0, 1, 5});
      tab.push_back('{12'h000, 0, 0, 5});
      tab.push_back('{12'h800, 0, 0, 5}); tab.push_back('{12'h800, 0, 0, 5});
      tab.push_back('{12'h800, 1, 1, 11});
      tab.push_back('{12'h000, 0, 1, 11}); tab.push_back('{12'h000, 0, 1, 11});
      tab.push_back('{12'h000, 0, 0, 11});
      repeat (10) tab.push_back('{12'h101, 0, 0, 11});
      tab.push_back('{12'h001, 0, 0, 11}); tab.push_back('{12'h001, 0, 0, 11});
      tab.push_back('{12'h001, 1, 1, 1});
      repeat (4) tab.push_back('{12'h002, 0, 1, 1});
      tab.push_back('{12'h000, 0, 1, 1}); tab.push_back('{12'h000, 0, 1, 1});
      tab.push_back('{12'h000, 0, 0, 1});

      model_reset();
      #12;
      check("rst_col", key_col, 1); check("rst_code", key_code, 15);
      check("rst_valid", key_valid, 0); check("rst_pressed", key_pressed, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      repeat (100) run_frame(12'h000);

      foreach (tab[i]) begin
         run_frame(tab[i].k);
         check("tab_valid", key_valid, tab[i].v);
         check("tab_pressed", key_pressed, tab[i].p);
         check("tab_code", key_code, tab[i].code);
      end

      // bounce on '0': two frames on, two off, never three identical
      for (int f = 0; f < 40; f++) run_frame(((f / 2) % 2 == 0) ? 12'h400 : 12'h000);
      repeat (3) run_frame(12'h400);
      check("bounce_code", key_code, 0);
      check("bounce_valid", key_valid, 1);
      repeat (3) run_frame(12'h000);

      for (int n = 0; n < 60; n++) begin
         logic [11:0] k;
         int sel;
         sel = $urandom_range(0, 3);
         k = '0;
         if (sel != 0) k[$urandom_range(0, 11)] = 1'b1;
         if (sel == 3) k[$urandom_range(0, 11)] = 1'b1;
         repeat ($urandom_range(1, 5)) run_frame(k);
      end

      repeat (3) run_frame(12'h000);
      run_frame(12'h010); run_frame(12'h010);
      repeat (5) @(posedge clk);
      #1 check("pre_rst_col", key_col, 2);
      #2 reset = 1'b0;
      #1;
      check("async_col", key_col, 1); check("async_code", key_code, 15);
      check("async_valid", key_valid, 0); check("async_pressed", key_pressed, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      run_frame(12'h010); run_frame(12'h010);
      check("rst_no_early", key_pressed, 0);
      run_frame(12'h010);
      check("rst_report", key_code, 5);
      check("rst_report_valid", key_valid, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
